cdc_hndshk_arbiter: RTL and testbench

CDC_HNDSHK_ARBITER -- requirements
Module: cdc_hndshk_arbiter

---
 rtl/cdc_hndshk_pkg.sv | 18 +
 rtl/cdc_rr_arbiter.sv | 38 +++
 rtl/cdc_hndshk_arbiter.sv | 142 ++++++++++++++
 tb/tb_cdc_hndshk_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_hndshk_pkg.sv
// Shared definitions for the CDC handshake arbiter: FSM state encoding and
// default sizing parameters.
package cdc_hndshk_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int TIMEOUT_DEF = 64;

  // state  | meaning
  // IDLE   | channel free, picking the next pending requester
  // LAUNCH | one-cycle launch pulse into the handshake source side
  // BUSY   | waiting for the source side to raise then drop its stall
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2
  } state_e;

endpackage

// File: rtl/cdc_rr_arbiter.sv
// Combinational round-robin pick: first pending requester at or after
// rr_ptr_i, wrapping modulo NUM_REQ. Returns one-hot grant and its index.
module cdc_rr_arbiter
  import cdc_hndshk_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
) (
  input  logic [NUM_REQ-1:0]         pending_i,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr_i,
  output logic [NUM_REQ-1:0]         gnt_oh_o,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o,
  output logic                       gnt_any_o
);

  localparam int IW = $clog2(NUM_REQ);

  logic found;
  int   slot;

  // Scan upward from the pointer, wrapping, and keep the first hit.
  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    slot      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      slot = int'(rr_ptr_i) + k;
      if (slot >= NUM_REQ) slot = slot - NUM_REQ;
      if (!found && pending_i[IW'(slot)]) begin
        found               = 1'b1;
        gnt_oh_o[IW'(slot)] = 1'b1;
        gnt_idx_o           = IW'(slot);
      end
    end
    gnt_any_o = found;
  end

endmodule

// File: rtl/cdc_hndshk_arbiter.sv
// Arbitrates NUM_REQ requesters onto one CDC handshake source channel.
// Optional BUSY timeout abort is enabled by defining CDC_ARB_TIMEOUT_EN;
// without it BUSY waits indefinitely and timeout_err_o is tied low.
// done_pulse_o and grant_valid_o react in the same cycle the source stall
// drops, so completion is visible in the first low-stall cycle.
module cdc_hndshk_arbiter
  import cdc_hndshk_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                       source_clk_i,
  input  logic                       source_reset_i,
  input  logic [NUM_REQ-1:0]         req_strobe_i,
  output logic [NUM_REQ-1:0]         req_stall_o,
  output logic                       source_strobe_o,
  input  logic                       source_stall_i,
  output logic                       grant_valid_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
  output logic [NUM_REQ-1:0]         done_pulse_o,
  output logic                       timeout_err_o
);

  localparam int IW = $clog2(NUM_REQ);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]      grant_id_q, grant_id_d;
  logic               seen_stall_q, seen_stall_d;

  logic [NUM_REQ-1:0] pick_oh;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic [NUM_REQ-1:0] owner_oh;
  logic               xfer_done;
  logic               grant_valid;
  logic               abort;

  cdc_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .pending_i (pending_q),
    .rr_ptr_i  (rr_ptr_q),
    .gnt_oh_o  (pick_oh),
    .gnt_idx_o (pick_idx),
    .gnt_any_o (pick_any)
  );

  assign xfer_done   = (state_q == BUSY) && seen_stall_q && !source_stall_i;
  assign grant_valid = (state_q == LAUNCH) || ((state_q == BUSY) && !xfer_done);

  // One-hot decode of the current owner.
  always_comb begin
    owner_oh             = '0;
    owner_oh[grant_id_q] = 1'b1;
  end

  assign req_stall_o     = pending_q | (grant_valid ? owner_oh : '0);
  assign source_strobe_o = (state_q == LAUNCH);
  assign grant_valid_o   = grant_valid;
  assign grant_id_o      = grant_id_q;
  assign done_pulse_o    = xfer_done ? owner_oh : '0;

`ifdef CDC_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT) + 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          terr_q, terr_d;

  assign abort = (state_q == BUSY) && !xfer_done && (cnt_q == CW'(TIMEOUT - 1));

  // BUSY cycle counter restarts from zero on every launch; error is sticky.
  always_comb begin
    cnt_d  = (state_q == BUSY) ? cnt_q + CW'(1) : '0;
    terr_d = terr_q | abort;
  end

  // Timeout counter and sticky error flag.
  always_ff @(posedge source_clk_i) begin
    if (source_reset_i) begin
      cnt_q  <= '0;
      terr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      terr_q <= terr_d;
    end
  end

  assign timeout_err_o = terr_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign abort          = 1'b0;
  assign timeout_err_o  = 1'b0;
`endif

  // Next-state: latch accepted strobes, grant from IDLE, track the stall handshake.
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q | (req_strobe_i & ~req_stall_o);
    rr_ptr_d     = rr_ptr_q;
    grant_id_d   = grant_id_q;
    seen_stall_d = seen_stall_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          pending_d    = pending_d & ~pick_oh;
          grant_id_d   = pick_idx;
          rr_ptr_d     = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + IW'(1);
          seen_stall_d = 1'b0;
          state_d      = LAUNCH;
        end
      end
      LAUNCH: state_d = BUSY;
      BUSY: begin
        if (source_stall_i) seen_stall_d = 1'b1;
        if (xfer_done || abort) begin
          seen_stall_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge source_clk_i) begin
    if (source_reset_i) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      rr_ptr_q     <= '0;
      grant_id_q   <= '0;
      seen_stall_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_id_q   <= grant_id_d;
      seen_stall_q <= seen_stall_d;
    end
  end

endmodule

// File: tb/tb_cdc_hndshk_arbiter.sv
// Scoreboard bench for cdc_hndshk_arbiter: expected grant order is pushed
// when strobes are driven and popped on each source_strobe launch.
module tb_cdc_hndshk_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req_strobe = '0;
  logic [3:0] req_stall;
  logic       source_strobe;
  logic       source_stall;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic [3:0] done_pulse;
  logic       timeout_err;

  cdc_hndshk_arbiter #(.NUM_REQ(4), .TIMEOUT(8)) dut (
    .source_clk_i    (clk),
    .source_reset_i  (rst),
    .req_strobe_i    (req_strobe),
    .req_stall_o     (req_stall),
    .source_strobe_o (source_strobe),
    .source_stall_i  (source_stall),
    .grant_valid_o   (grant_valid),
    .grant_id_o      (grant_id),
    .done_pulse_o    (done_pulse),
    .timeout_err_o   (timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int q[$];
  int owner = -1;
  int done_cnt = 0;
  bit prev_strb = 1'b0;
  bit launch_seen = 1'b0;
  int stall_len = 3;
  bit stall_stuck = 1'b0;
  int stall_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Handshake source emulator: stall rises the cycle after launch for stall_len cycles.
  initial begin
    source_stall = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (stall_stuck) begin
        source_stall = 1'b1;
        stall_cnt    = 0;
      end else begin
        if (launch_seen) stall_cnt = stall_len;
        if (stall_cnt > 0) begin
          source_stall = 1'b1;
          stall_cnt--;
        end else begin
          source_stall = 1'b0;
        end
      end
    end
  end

  // Monitor: scoreboard pop on launch, done/owner consistency, no adjacent launches.
  initial begin
    int exp;
    forever begin
      @(negedge clk);
      launch_seen = source_strobe;
      if (!rst) begin
        if (source_strobe) begin
          check_eq("strb_adjacent", prev_strb, 0);
          check_eq("strb_gv", grant_valid, 1);
          check_eq("sb_pending", q.size() > 0, 1);
          if (q.size() > 0) begin
            exp = q.pop_front();
            check_eq("grant_id", grant_id, exp);
            owner = exp;
          end
        end
        if (done_pulse != 0) begin
          done_cnt++;
          check_eq("done_oh", done_pulse, (owner >= 0) ? (1 << owner) : 0);
          check_eq("done_gv", grant_valid, 0);
        end
`ifndef CDC_ARB_TIMEOUT_EN
        check_eq("terr_tied", timeout_err, 0);
`endif
      end
      prev_strb = source_strobe;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    req_strobe = '0;
    stall_stuck = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_strb", source_strobe, 0);
    check_eq("rst_gv", grant_valid, 0);
    check_eq("rst_gid", grant_id, 0);
    check_eq("rst_done", done_pulse, 0);
    check_eq("rst_stall", req_stall, 0);
    check_eq("rst_terr", timeout_err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    owner = -1;
    prev_strb = 1'b0;
  endtask

  task automatic pulse_req(input logic [3:0] v);
    req_strobe = v;
    @(posedge clk); #1;
    req_strobe = '0;
  endtask

  task automatic wait_launch(input int id);
    bit hit = 1'b0;
    for (int n = 0; n < 100 && !hit; n++) begin
      @(negedge clk);
      if (source_strobe && grant_id == 2'(id)) hit = 1'b1;
    end
    check_eq("wait_launch", hit, 1);
  endtask

  task automatic drain();
    bit idle = 1'b0;
    for (int n = 0; n < 300 && !idle; n++) begin
      @(negedge clk);
      idle = (q.size() == 0) && !grant_valid && (req_stall == 0) && !source_strobe;
    end
    check_eq("drain", idle, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired @%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;

    // Single request: launch at cycle 2, stall 3..5, done at cycle 6.
    do_reset();
    stall_len = 3;
    req_strobe = 4'b0001;
    q.push_back(0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check_eq("t1_strb", source_strobe, k == 2);
      check_eq("t1_gv", grant_valid, (k >= 2) && (k <= 5));
      check_eq("t1_done", done_pulse, (k == 6) ? 1 : 0);
      check_eq("t1_stall0", req_stall[0], (k >= 1) && (k <= 5));
      @(posedge clk); #1;
      req_strobe = '0;
    end

    // All four at once from rr_ptr=0: order 0,1,2,3.
    do_reset();
    stall_len = 1;
    d0 = done_cnt;
    q.push_back(0); q.push_back(1); q.push_back(2); q.push_back(3);
    pulse_req(4'b1111);
    drain();
    check_eq("t2_done_cnt", done_cnt - d0, 4);

    // Round-robin after grant 2; owner's own strobe dropped.
    do_reset();
    stall_len = 4;
    d0 = done_cnt;
    q.push_back(2);
    pulse_req(4'b0100);
    wait_launch(2);
    @(posedge clk); #1;
    check_eq("t3_stall_a", req_stall, 4'b0100);
    q.push_back(3); q.push_back(0);
    pulse_req(4'b1101);
    check_eq("t3_stall_b", req_stall, 4'b1101);
    wait_launch(0);
    @(posedge clk); #1;
    check_eq("t3_stall_c", req_stall, 4'b0001);
    q.push_back(2);
    pulse_req(4'b0101);
    check_eq("t3_stall_d", req_stall, 4'b0101);
    drain();
    check_eq("t3_done_cnt", done_cnt - d0, 4);

    // Repeated strobes from requester 1 while stalled: one transfer only.
    stall_len = 3;
    d0 = done_cnt;
    q.push_back(1);
    req_strobe = 4'b0010;
    @(negedge clk);
    check_eq("t4_stall_c0", req_stall[1], 0);
    @(posedge clk); #1;
    check_eq("t4_stall_c1", req_stall[1], 1);
    repeat (3) @(posedge clk);
    #1 req_strobe = '0;
    drain();
    check_eq("t4_done_cnt", done_cnt - d0, 1);

    // Reset during BUSY: outputs clear, pending dropped, rr_ptr back to 0.
    stall_stuck = 1'b1;
    d0 = done_cnt;
    q.push_back(0);
    pulse_req(4'b0001);
    wait_launch(0);
    @(posedge clk); #1;
    pulse_req(4'b0100);
    check_eq("t5_stall_pre", req_stall, 4'b0101);
    rst = 1'b1;
    stall_stuck = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    owner = -1;
    @(negedge clk);
    check_eq("t5_strb", source_strobe, 0);
    check_eq("t5_gv", grant_valid, 0);
    check_eq("t5_gid", grant_id, 0);
    check_eq("t5_done", done_pulse, 0);
    check_eq("t5_stall", req_stall, 0);
    @(posedge clk); #1;
    stall_len = 2;
    q.push_back(0); q.push_back(1);
    pulse_req(4'b0011);
    drain();
    check_eq("t5_done_cnt", done_cnt - d0, 2);

`ifdef CDC_ARB_TIMEOUT_EN
    // Stuck stall: abort after 8 BUSY cycles, sticky error, next pending served.
    do_reset();
    stall_stuck = 1'b1;
    stall_len = 2;
    d0 = done_cnt;
    q.push_back(0); q.push_back(1);
    pulse_req(4'b0001);
    pulse_req(4'b0010);
    wait_launch(0);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check_eq("t6_gv", grant_valid, k <= 8);
      check_eq("t6_terr", timeout_err, k >= 9);
      if (k == 9) stall_stuck = 1'b0;
    end
    check_eq("t6_no_done", done_cnt - d0, 0);
    drain();
    check_eq("t6_done_cnt", done_cnt - d0, 1);
    check_eq("t6_terr_sticky", timeout_err, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
